// File: rtl/bsram_18k_x36.sv
// Single-port 512 x 36 block SRAM with byte-lane writes, selectable write-port
// output behaviour and an optional output pipeline register.
module bsram_18k_x36 #(
    parameter int unsigned READ_MODE  = 0,
    parameter int unsigned WRITE_MODE = 0,
    parameter int unsigned BE_EN      = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    input  logic        WRE,
    input  logic [13:0] AD,
    input  logic [35:0] DI,
    output logic [35:0] DO
);

    localparam int unsigned WM_NORMAL = 0;
    localparam int unsigned WM_THRU   = 1;
    localparam int unsigned WM_RBW    = 2;

    // The array has no reset; it starts cleared and only writes change it.
    logic [35:0] mem_q [0:511] = '{default: '0};

    logic [35:0] outLatch_q;
    logic [35:0] outLatch_d;
    logic [35:0] pipeReg_q;
    logic [35:0] pipeReg_d;

    logic [8:0]  wordAddr;
    logic [3:0]  laneEn;
    logic [35:0] laneMask;
    logic [35:0] oldWord;
    logic [35:0] mergedWord;
    logic        portActive;
    logic        unusedAdBit;

    assign wordAddr    = AD[13:5];
    assign unusedAdBit = AD[4];
    assign portActive  = ~CE;

    always_comb begin
        laneEn = 4'hF;
        if (BE_EN != 0) begin
            laneEn = AD[3:0];
        end
    end

    assign laneMask = {{9{laneEn[3]}}, {9{laneEn[2]}}, {9{laneEn[1]}}, {9{laneEn[0]}}};

    // Merged word is both what the array stores and what write-through shows.
    assign oldWord    = mem_q[wordAddr];
    assign mergedWord = (DI & laneMask) | (oldWord & ~laneMask);

    always_ff @(posedge CLK) begin
        if (portActive && WRE) begin
            mem_q[wordAddr] <= mergedWord;
        end
    end

    always_comb begin
        outLatch_d = outLatch_q;
        pipeReg_d  = pipeReg_q;
        if (portActive) begin
            pipeReg_d = outLatch_q;
            if (WRE) begin
                case (WRITE_MODE)
                    WM_THRU:   outLatch_d = mergedWord;
                    WM_RBW:    outLatch_d = oldWord;
                    WM_NORMAL: outLatch_d = outLatch_q;
                    default:   outLatch_d = outLatch_q;
                endcase
            end else begin
                outLatch_d = oldWord;
            end
        end
    end

    // Reset clears only the output side and holds it cleared while low.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            outLatch_q <= '0;
            pipeReg_q  <= '0;
        end else begin
            outLatch_q <= outLatch_d;
            pipeReg_q  <= pipeReg_d;
        end
    end

    assign DO = (READ_MODE != 0) ? pipeReg_q : outLatch_q;

endmodule

// File: tb/tb_bsram_18k_x36.sv
// Directed bench driving four differently configured BSRAM instances with
// shared stimulus and checking each output against hand-computed values.
module tb_bsram_18k_x36;

    logic        clk;
    logic        resetN;
    logic        ce;
    logic        wre;
    logic [13:0] ad;
    logic [35:0] di;
    logic [35:0] doA;
    logic [35:0] doB;
    logic [35:0] doC;
    logic [35:0] doD;

    int checkCount;
    int errorCount;

    // A: bypass/normal/no-BE, B: bypass/write-through/BE, C: bypass/RBW/no-BE, D: pipeline/normal/BE
    bsram_18k_x36 #(.READ_MODE(0), .WRITE_MODE(0), .BE_EN(0)) dutA (
        .CLK(clk), .RESET(resetN), .CE(ce), .WRE(wre), .AD(ad), .DI(di), .DO(doA));
    bsram_18k_x36 #(.READ_MODE(0), .WRITE_MODE(1), .BE_EN(1)) dutB (
        .CLK(clk), .RESET(resetN), .CE(ce), .WRE(wre), .AD(ad), .DI(di), .DO(doB));
    bsram_18k_x36 #(.READ_MODE(0), .WRITE_MODE(2), .BE_EN(0)) dutC (
        .CLK(clk), .RESET(resetN), .CE(ce), .WRE(wre), .AD(ad), .DI(di), .DO(doC));
    bsram_18k_x36 #(.READ_MODE(1), .WRITE_MODE(0), .BE_EN(1)) dutD (
        .CLK(clk), .RESET(resetN), .CE(ce), .WRE(wre), .AD(ad), .DI(di), .DO(doD));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [13:0] adOf(input logic [8:0] word, input logic [3:0] be);
        return {word, 1'b0, be};
    endfunction

    task automatic checkOutput(input string tag, input logic [35:0] actual, input logic [35:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ceIn, input logic wreIn, input logic [13:0] adIn,
                                 input logic [35:0] diIn);
        ce  = ceIn;
        wre = wreIn;
        ad  = adIn;
        di  = diIn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount = 0;
        errorCount = 0;
        resetN = 1'b0;
        ce     = 1'b1;
        wre    = 1'b0;
        ad     = '0;
        di     = '0;
        #3;
        checkOutput("resetA", doA, 36'h0);
        checkOutput("resetD", doD, 36'h0);
        resetN = 1'b1;

        applyStimulus(1'b0, 1'b0, adOf(9'd0, 4'hF), 36'h0);
        checkOutput("idleReadA", doA, 36'h0);

        applyStimulus(1'b0, 1'b1, adOf(9'd5, 4'hF), 36'h123456789);
        checkOutput("wr5ThruB", doB, 36'h123456789);
        checkOutput("wr5RbwC", doC, 36'h0);
        applyStimulus(1'b0, 1'b0, adOf(9'd5, 4'hF), 36'h0);
        checkOutput("rd5A", doA, 36'h123456789);
        checkOutput("rd5PipeEarlyD", doD, 36'h0);
        applyStimulus(1'b0, 1'b0, adOf(9'd6, 4'hF), 36'h0);
        checkOutput("rd6A", doA, 36'h0);
        checkOutput("rd5PipeD", doD, 36'h123456789);

        applyStimulus(1'b0, 1'b1, adOf(9'd7, 4'hF), 36'hFFFFFFFFF);
        checkOutput("wr7ThruB", doB, 36'hFFFFFFFFF);
        applyStimulus(1'b0, 1'b1, adOf(9'd7, 4'b0101), 36'h0);
        checkOutput("wr7BeThruB", doB, 36'hFF803FE00);
        checkOutput("wr7RbwC", doC, 36'hFFFFFFFFF);
        applyStimulus(1'b0, 1'b0, adOf(9'd7, 4'hF), 36'h0);
        checkOutput("rd7NoBeA", doA, 36'h0);
        checkOutput("rd7BeB", doB, 36'hFF803FE00);
        checkOutput("rd7NoBeC", doC, 36'h0);
        applyStimulus(1'b0, 1'b0, adOf(9'd7, 4'hF), 36'h0);
        checkOutput("rd7BePipeD", doD, 36'hFF803FE00);

        applyStimulus(1'b0, 1'b1, adOf(9'd3, 4'hF), 36'hAAA);
        applyStimulus(1'b0, 1'b0, adOf(9'd5, 4'hF), 36'h0);
        checkOutput("rd5BeforeWmA", doA, 36'h123456789);
        applyStimulus(1'b0, 1'b1, adOf(9'd3, 4'hF), 36'h555);
        checkOutput("wmNormalA", doA, 36'h123456789);
        checkOutput("wmThruB", doB, 36'h555);
        checkOutput("wmRbwC", doC, 36'hAAA);
        checkOutput("wmPipeD", doD, 36'h123456789);
        applyStimulus(1'b0, 1'b0, adOf(9'd3, 4'hF), 36'h0);
        checkOutput("rd3A", doA, 36'h555);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, adOf(9'd3, 4'hF), 36'hFFF);
        end
        checkOutput("ceFreezeA", doA, 36'h555);
        checkOutput("ceFreezeD", doD, 36'h123456789);
        applyStimulus(1'b0, 1'b0, adOf(9'd3, 4'hF), 36'h0);
        checkOutput("ceNoWriteA", doA, 36'h555);
        checkOutput("ceNoWriteD", doD, 36'h555);

        applyStimulus(1'b0, 1'b0, adOf(9'd5, 4'hF), 36'h0);
        applyStimulus(1'b0, 1'b0, adOf(9'd5, 4'hF), 36'h0);
        checkOutput("streamD", doD, 36'h123456789);
        #3;
        resetN = 1'b0;
        #1;
        checkOutput("asyncRstA", doA, 36'h0);
        checkOutput("asyncRstD", doD, 36'h0);
        applyStimulus(1'b0, 1'b1, adOf(9'd9, 4'hF), 36'h00000BEEF);
        checkOutput("rstHoldA", doA, 36'h0);
        checkOutput("rstHoldB", doB, 36'h0);
        resetN = 1'b1;
        applyStimulus(1'b0, 1'b0, adOf(9'd9, 4'hF), 36'h0);
        checkOutput("wrDuringRstA", doA, 36'h00000BEEF);
        checkOutput("postRstPipeD", doD, 36'h0);
        applyStimulus(1'b0, 1'b0, adOf(9'd5, 4'hF), 36'h0);
        checkOutput("intactA", doA, 36'h123456789);
        checkOutput("wrDuringRstD", doD, 36'h00000BEEF);

        applyStimulus(1'b0, 1'b0, adOf(9'd5, 4'hF) | 14'h0010, 36'h0);
        checkOutput("ad4IgnoredA", doA, 36'h123456789);
        applyStimulus(1'b0, 1'b1, adOf(9'd511, 4'hF), 36'h800000001);
        applyStimulus(1'b0, 1'b0, adOf(9'd511, 4'hF), 36'h0);
        checkOutput("rd511A", doA, 36'h800000001);
        applyStimulus(1'b0, 1'b0, adOf(9'd0, 4'hF), 36'h0);
        checkOutput("rd0A", doA, 36'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
